fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
- Read-side controller for the team's 8-bit, 16-deep synchronous FIFO. Drives the FIFO read enable using the FIFO's empty flag, and absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer.
- Presents the words as a valid/ready stream with packet framing (m_last every PKT_LEN words).
- Sits between the FIFO and any downstream consumer, so consumers never handle the re/empty protocol directly.

Parameters:
DW, 8, data width; matches FIFO data_out width.
PKT_LEN, 4, words per packet; m_last marks word PKT_LEN-1 of each packet; legal range 1..256.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  level enable; 1 = fetch from FIFO, 0 = stop fetching and drain
fifo_empty  input  1  FIFO empty flag
fifo_rdata  input  DW  FIFO data_out; valid the cycle after fifo_re was high
fifo_re  output  1  FIFO read enable (combinational)
m_valid  output  1  output word valid
m_data  output  DW  output word (head of skid buffer)
m_last  output  1  last word of packet, qualified by m_valid
m_ready  input  1  downstream accept
busy  output  1  controller not IDLE
word_cnt  output  16  total words handed off since reset; wraps 65535->0

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, rst). Asserting rst at any time, including mid-packet, immediately forces state IDLE and clears:
  - fifo_re, m_valid, m_last and busy to 0;
  - m_data to 0;
  - buffer count, pending flag, packet index and word_cnt to 0.
  - Any word in flight from the FIFO is discarded.
- Definitions:
  - pop = m_valid & m_ready.
  - cnt = skid occupancy, 0..2.
  - pend = registered copy of fifo_re from the previous cycle.
- fifo_re = (state==RUN) & ~fifo_empty & ((cnt + pend - pop) < 2). It never asserts while fifo_empty=1, in IDLE, or in STOP.
- Capture: when pend=1, fifo_rdata is written into the buffer tail at the end of that cycle.
  - Write and pop in the same cycle are legal; cnt is unchanged and ordering is preserved.
  - The buffer never overflows by construction. Overflow is an assertion failure in the bench.
- Latency: fifo_re high in cycle N -> data in FIFO cycle N+1 -> m_valid high in cycle N+2, given cnt was 0.
- Throughput: with m_ready=1 and the FIFO non-empty, sustains 1 word per cycle.
- Stream rules:
  - m_valid = (cnt != 0).
  - m_data and m_last hold stable while m_valid & ~m_ready.
  - m_valid never drops without a pop.
- Framing:
  - pkt_idx increments on each pop and wraps to 0 after PKT_LEN-1.
  - m_last = m_valid & (pkt_idx == PKT_LEN-1).
  - PKT_LEN=1 gives m_last on every word.
  - pkt_idx persists across STOP/IDLE; packets are not truncated by en.
- word_cnt increments on each pop, with 16-bit wrap.
- FSM (busy = state != IDLE):
  - IDLE: en=1 -> RUN.
  - RUN: en=0 -> STOP. Otherwise stay in RUN; FIFO empty just gates fifo_re.
  - STOP: no new reads. The pending word is captured and the buffer drains. When pend=0 & cnt=0: go to RUN if en=1, else IDLE.
- en toggling in RUN is safe. A read already issued is always captured, never lost.

Test Plan:
- Reset and idle: rst pulse with en=0 and the FIFO holding 5 words -> fifo_re=0, m_valid=0, busy=0, word_cnt=0 for 20 cycles.
- Streaming: FIFO preloaded with 0x00..0x0F, en=1, m_ready=1, PKT_LEN=4 -> fifo_re first in cycle N, m_valid first in cycle N+2. Expected outputs:
  - 16 consecutive words 0x00..0x0F, one per cycle;
  - m_last on 0x03, 0x07, 0x0B, 0x0F;
  - word_cnt=16;
  - fifo_re never high while empty.
- Backpressure: same data; m_ready toggles 1,0,0,1 repeating -> no word lost or duplicated, m_data stable while stalled, cnt never exceeds 2.
- Stop mid-stream: drop en after the 6th pop with the FIFO still holding 10 words -> at most 2 further words delivered (0x06, 0x07), then busy falls. Re-assert en -> stream resumes at the next word, and m_last is still on 0x0B.
- Async reset mid-packet: rst asserted between clock edges while m_valid=1 and pend=1 -> all outputs 0 immediately, no edge required. After release with en=1, fetching restarts and pkt_idx=0.
- Wrap: preset via 65535 pops, then one more pop -> word_cnt=0.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
// Read-side controller for the 8-bit, 16-deep synchronous FIFO. Issues FIFO
// reads from the empty flag, absorbs the FIFO's one-cycle read latency in a
// 2-entry skid buffer, and presents the words as a valid/ready stream with
// packet framing (m_last on every PKT_LEN-th word).
module fifo_rd_ctrl #(
    parameter int DW      = 8,
    parameter int PKT_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_re,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic [15:0]   word_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Packet index of the last word in a packet; PKT_LEN is at most 256.
    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    state_t        state;
    state_t        state_nxt;

    // Skid buffer: buf0 is the head presented on m_data, buf1 the tail slot.
    logic [1:0]    cnt;
    logic [1:0]    cnt_nxt;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic [DW-1:0] buf0_nxt;
    logic [DW-1:0] buf1_nxt;

    // A read was issued last cycle, so fifo_rdata carries a word this cycle.
    logic          pend;

    logic [7:0]    pkt_idx;
    logic [15:0]   wcnt;

    logic          pop;
    logic          wr;
    logic [2:0]    occ;

    assign m_valid = (cnt != 2'd0);
    assign pop     = m_valid & m_ready;
    assign wr      = pend;

    // Occupancy the buffer will have once this cycle's pending word lands and
    // this cycle's pop leaves. cnt==0 implies no pop, so this never underflows.
    assign occ     = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};

    // A new read is only issued when its word is guaranteed a free slot.
    assign fifo_re = (state == RUN) & ~fifo_empty & (occ < 3'd2);

    assign m_data   = buf0;
    assign m_last   = m_valid & (pkt_idx == LAST_IDX);
    assign busy     = (state != IDLE);
    assign word_cnt = wcnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: STOP waits for the in-flight read and the buffer to drain.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (!pend && (cnt == 2'd0)) begin
                    state_nxt = en ? RUN : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pending flag: remembers that a FIFO read was issued in the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            pend <= fifo_re;
        end
    end

    // Skid buffer next state: capture into the tail, shift on pop, keep order.
    always_comb begin
        buf0_nxt = buf0;
        buf1_nxt = buf1;
        cnt_nxt  = cnt;
        case ({wr, pop})
            2'b01: begin
                buf0_nxt = buf1;
                cnt_nxt  = cnt - 2'd1;
            end
            2'b10: begin
                if (cnt == 2'd0) begin
                    buf0_nxt = fifo_rdata;
                end else begin
                    buf1_nxt = fifo_rdata;
                end
                cnt_nxt = cnt + 2'd1;
            end
            2'b11: begin
                if (cnt == 2'd1) begin
                    buf0_nxt = fifo_rdata;
                end else begin
                    buf0_nxt = buf1;
                    buf1_nxt = fifo_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Skid buffer registers; reset also clears the data so m_data reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            cnt  <= cnt_nxt;
            buf0 <= buf0_nxt;
            buf1 <= buf1_nxt;
        end
    end

    // Packet index: advances on every handed-off word, survives STOP/IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_idx <= 8'd0;
        end else if (pop) begin
            if (pkt_idx == LAST_IDX) begin
                pkt_idx <= 8'd0;
            end else begin
                pkt_idx <= pkt_idx + 8'd1;
            end
        end
    end

    // Running count of handed-off words, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= 16'd0;
        end else if (pop) begin
            wcnt <= wcnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl
// Directed bench for fifo_rd_ctrl with a behavioural FIFO model, an in-order
// scoreboard and a PKT_LEN=1 twin instance sharing the same inputs.
module tb_fifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        m_ready = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rdata = 8'd0;
    logic        fifo_re;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;
    logic [15:0] word_cnt;

    logic        fifo_re2;
    logic        m_valid2;
    logic [7:0]  m_data2;
    logic        m_last2;
    logic        busy2;
    logic [15:0] word_cnt2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // FIFO model state (owned by the FIFO process).
    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic [7:0] fw;
    logic [7:0] fill_val = 8'd0;
    logic       load_ack = 1'b0;
    logic       clr_ack = 1'b0;

    // FIFO model requests (owned by the stimulus process).
    logic       load_req = 1'b0;
    logic       clr_req = 1'b0;
    logic [7:0] load_base = 8'd0;
    int         load_n = 0;
    logic       refill = 1'b0;

    // Monitor state.
    int          exp_rd = 0;
    logic [7:0]  mdl_pidx = 8'd0;
    logic [15:0] mdl_wc = 16'd0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    logic        prev_last = 1'b0;

    fifo_rd_ctrl #(.DW(8), .PKT_LEN(4)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_re(fifo_re), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy),
        .word_cnt(word_cnt)
    );

    fifo_rd_ctrl #(.DW(8), .PKT_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_re(fifo_re2), .m_valid(m_valid2),
        .m_data(m_data2), .m_last(m_last2), .m_ready(m_ready), .busy(busy2),
        .word_cnt(word_cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // FIFO model: registered read data one cycle after fifo_re, words in flight
    // at reset are dropped from the expected stream.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else if (fifo_re && (q.size() != 0)) begin
            fw = q.pop_front();
            fifo_rdata <= fw;
            exp_q.push_back(fw);
        end
        if (clr_req != clr_ack) begin
            q.delete();
            clr_ack <= clr_req;
        end
        if (load_req != load_ack) begin
            for (int i = 0; i < load_n; i++) q.push_back(8'(load_base + 8'(i)));
            load_ack <= load_req;
        end
        if (refill && !rst && (q.size() < 8)) begin
            q.push_back(fill_val);
            fill_val = fill_val + 8'd1;
        end
        fifo_empty <= (q.size() == 0);
    end

    // Stream monitor: ordering, framing, word count, stall stability, overflow.
    always @(negedge clk) begin
        if (rst) begin
            exp_rd     = 0;
            mdl_pidx   = 8'd0;
            mdl_wc     = 16'd0;
            prev_stall = 1'b0;
        end else begin
            if (fifo_empty) chk("re_while_empty", fifo_re, 1'b0);
            chk("overflow", dut.cnt > 2'd2, 1'b0);
            chk("twin", {fifo_re2, m_valid2, m_data2, busy2, word_cnt2},
                {fifo_re, m_valid, m_data, busy, word_cnt});
            chk("len1_last", m_last2, m_valid2);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                chk("data_avail", exp_q.size() > exp_rd, 1'b1);
                if (exp_q.size() > exp_rd) chk("data", m_data, exp_q[exp_rd]);
                chk("last", m_last, mdl_pidx == 8'd3);
                chk("wcnt", word_cnt, mdl_wc);
                exp_rd++;
                mdl_pidx = (mdl_pidx == 8'd3) ? 8'd0 : mdl_pidx + 8'd1;
                mdl_wc   = mdl_wc + 16'd1;
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] base, input int n);
        load_base = base;
        load_n    = n;
        load_req  = ~load_req;
        step();
    endtask

    task automatic fifo_clear();
        clr_req = ~clr_req;
        step();
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int c0;
        int re_cyc;
        int mv_cyc;
        int last_cyc;
        int k;
        bit [3:0] pat;
        logic [15:0] base_wc;

        // Reset and idle: FIFO holds 5 words, en low.
        load(8'hA0, 5);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, 8'h00);
        chk("rst_wcnt", word_cnt, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_re", fifo_re, 1'b0);
            chk("idle_valid", m_valid, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_wcnt", word_cnt, 16'd0);
        end
        fifo_clear();

        // Streaming 0x00..0x0F at full rate.
        load(8'h00, 16);
        c0 = cyc;
        en = 1'b1;
        re_cyc = -1;
        mv_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_re && re_cyc < 0) re_cyc = cyc;
            if (m_valid) begin
                mv_cyc = cyc;
                break;
            end
        end
        chk("lat_re", re_cyc - c0, 1);
        chk("lat_valid", mv_cyc - re_cyc, 2);
        last_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_valid && m_ready && word_cnt == 16'd15) begin
                last_cyc = cyc;
                break;
            end
        end
        chk("thruput", last_cyc - mv_cyc, 15);
        @(negedge clk);
        chk("stream_wcnt", word_cnt, 16'd16);
        step();
        en = 1'b0;
        wait_idle("stream_idle");

        // Backpressure with m_ready pattern 1,0,0,1.
        load(8'h00, 16);
        en = 1'b1;
        pat = 4'b1001;
        k = 0;
        for (int i = 0; i < 200; i++) begin
            m_ready = pat[k % 4];
            k++;
            step();
            if (word_cnt == 16'd32) break;
        end
        chk("bp_wcnt", word_cnt, 16'd32);
        m_ready = 1'b1;
        en = 1'b0;
        wait_idle("bp_idle");
        chk("bp_drained", exp_q.size(), exp_rd);

        // Stop mid-stream: en falls with the 6th pop.
        load(8'h00, 16);
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (word_cnt == 16'd37) begin
                en = 1'b0;
                break;
            end
        end
        base_wc = word_cnt + 16'd1;
        wait_idle("stop_idle");
        chk("stop_extra", word_cnt - base_wc, 16'd2);
        chk("stop_fifo_left", q.size(), 8);
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_valid && m_ready && m_data == 8'h0B) chk("last_0b", m_last, 1'b1);
            if (word_cnt == 16'd48) break;
        end
        chk("resume_wcnt", word_cnt, 16'd48);
        step();
        en = 1'b0;
        wait_idle("resume_idle");

        // Asynchronous reset mid-packet with a read pending.
        load(8'h00, 16);
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (word_cnt == 16'd50) break;
        end
        chk("pre_rst_valid", m_valid, 1'b1);
        chk("pre_rst_pend", dut.pend, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_re", fifo_re, 1'b0);
        chk("arst_valid", m_valid, 1'b0);
        chk("arst_last", m_last, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_data", m_data, 8'h00);
        chk("arst_wcnt", word_cnt, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) chk("arst_pkt_last", m_last, word_cnt == 16'd3);
            if (word_cnt == 16'd4) break;
        end
        chk("arst_restart", word_cnt, 16'd4);
        step();
        en = 1'b0;
        wait_idle("arst_idle");
        fifo_clear();

        // Word counter wrap.
        do_reset();
        refill = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            step();
            if (word_cnt == 16'hFFFF) break;
        end
        chk("wrap_pre", word_cnt, 16'hFFFF);
        chk("wrap_valid", m_valid, 1'b1);
        step();
        chk("wrap", word_cnt, 16'd0);
        en = 1'b0;
        refill = 1'b0;
        wait_idle("wrap_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
